// File: rtl/uart_frame_arbiter_pkg.sv
// Shared definitions for the UART frame arbiter and the frame generators
// that feed it.
//   arb_state_t     : arbiter FSM state encoding (IDLE / XFER / GAP)
//   FRAME_*         : fixed header/trailer bytes and total length of the
//                     coordinate frame, reused by the generators
//   frame_hdr_byte  : byte n (0 = first on the wire) of the frame header
package uart_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int          FRAME_LEN     = 11;
    localparam int          FRAME_HDR_LEN = 5;
    localparam int          FRAME_TRL_LEN = 2;
    localparam logic [39:0] FRAME_HDR     = 40'hC0_C0_06_01_B9;
    localparam logic [15:0] FRAME_TRL     = 16'h01_CF;

    // Header is stored first-byte-in-MSBs so it reads like the wire order.
    function automatic logic [7:0] frame_hdr_byte(input int n);
        return FRAME_HDR[8*(FRAME_HDR_LEN-1-n) +: 8];
    endfunction

endpackage

// File: rtl/uart_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches req starting at last_ptr+1 (mod NUM_REQ) and returns the first
// requester found.
//   req      in  NUM_REQ  request vector
//   last_ptr in  PTR_W    index of the previous winner
//   grant    out NUM_REQ  one-hot winner (0 when no request)
//   idx      out PTR_W    binary index of the winner
//   valid    out 1        at least one request present
module rr_arbiter
    import uart_frame_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    // Requester i sits k places after last_ptr when last_ptr == (i-k) mod N.
    // Walking k = 1..N and taking the first hit yields the rotating priority
    // while keeping every bit-select index constant.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] &&
                    (last_ptr == PTR_W'((i - k + NUM_REQ) % NUM_REQ))) begin
                    valid    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Shares one uart_tx byte channel between NUM_REQ frame sources.
// Round-robin at frame granularity, a programmable idle gap after each frame,
// and abort of frames whose source starves the channel for STALL_MAX cycles.
//   clk_a      in  1          system clock
//   rst_n      in  1          asynchronous active-low reset
//   req_data   in  8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_valid  in  NUM_REQ    requester i offers a byte
//   req_last   in  NUM_REQ    offered byte ends the frame
//   req_ready  out NUM_REQ    byte of requester i consumed this cycle
//   tx_data    out 8          byte to uart_tx
//   tx_valid   out 1          tx_data valid
//   tx_ready   in  1          uart_tx accepting
//   grant      out NUM_REQ    one-hot channel owner, 0 when none
//   busy       out 1          FSM not idle
//   err_stall  out 1          one-cycle pulse on stall abort
//   frame_cnt  out CNT_W      frames completed normally (wraps)
module uart_frame_arbiter
    import uart_frame_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 1_000_000,
    parameter int STALL_MAX  = 65535,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_a,
    input  logic                 rst_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 err_stall,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int PTR_W      = $clog2(NUM_REQ);
    // GAP lasts at least one cycle even when GAP_CYCLES is 0.
    localparam int GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W      = $clog2(GAP_LAST + 1) + 1;
    localparam int STALL_LAST = (STALL_MAX > 0) ? STALL_MAX - 1 : 0;
    localparam int STALL_W    = $clog2(STALL_LAST + 1) + 1;

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               last_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req      (req_valid),
        .last_ptr (rr_ptr),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // grant is one-hot (or zero), so OR-reduction is a clean mux.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data  = sel_data | req_data[8*i +: 8];
                sel_valid = sel_valid | req_valid[i];
                sel_last  = sel_last | req_last[i];
            end
        end
    end

    // A byte is taken only while the single-entry tx holding register is empty.
    assign req_ready = (state == XFER && !tx_valid) ? grant : '0;

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= PTR_W'(NUM_REQ - 1);
            gap_cnt   <= '0;
            stall_cnt <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            err_stall <= 1'b0;
            frame_cnt <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            err_stall <= 1'b0;
            case (state)
                IDLE: begin
                    // Decision cycle only; the first byte is taken in XFER.
                    if (pick_valid) begin
                        grant     <= pick_grant;
                        rr_ptr    <= pick_idx;
                        stall_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (tx_valid) begin
                        // Waiting on uart_tx is not source starvation.
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (last_q) begin
                                frame_cnt <= frame_cnt + 1'b1;
                                grant     <= '0;
                                gap_cnt   <= '0;
                                state     <= GAP;
                            end
                        end
                    end else if (sel_valid) begin
                        tx_data   <= sel_data;
                        tx_valid  <= 1'b1;
                        last_q    <= sel_last;
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_W'(STALL_LAST)) begin
                        // STALL_MAX-th starved cycle: drop the partial frame.
                        err_stall <= 1'b1;
                        grant     <= '0;
                        stall_cnt <= '0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // Overlaps uart_tx still shifting out the final byte.
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    grant    <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
